// File: rtl/matmul_pkg.sv
// Shared definitions for the matrix multiplier, its result collector and writer-side benches.
package matmul_pkg;
  localparam int MAT_W = 32;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    DRAIN   = 2'd2,
    DONE    = 2'd3
  } coll_state_e;
endpackage

// File: rtl/matrix_result_collector_if.sv
// Result-input (stb/ack) and drain (valid/ready) channels of the matrix result collector.
interface matrix_result_collector_if
  import matmul_pkg::*;
#(
  parameter int M = 4,
  parameter int W = MAT_W
);
  localparam int IW = $clog2(M);

  logic [W-1:0]  z_out;
  logic [IW-1:0] z_i;
  logic [IW-1:0] z_j;
  logic          z_stb;
  logic          z_ack;

  logic [W-1:0]  out_data;
  logic [IW-1:0] out_i;
  logic [IW-1:0] out_j;
  logic          out_valid;
  logic          out_ready;

  modport master (
    output z_out, z_i, z_j, z_stb,
    input  z_ack,
    input  out_data, out_i, out_j, out_valid,
    output out_ready
  );

  modport slave (
    input  z_out, z_i, z_j, z_stb,
    output z_ack,
    output out_data, out_i, out_j, out_valid,
    input  out_ready
  );
endinterface

// File: rtl/matrix_result_collector_result_store.sv
// M x M element buffer with one write port, one combinational read port and a written-bitmap.
module result_store #(
  parameter  int M  = 4,
  parameter  int W  = 32,
  localparam int IW = $clog2(M)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          we,
  input  logic [IW-1:0] wr_i,
  input  logic [IW-1:0] wr_j,
  input  logic [W-1:0]  wr_data,
  output logic          wr_seen,
  input  logic [IW-1:0] rd_i,
  input  logic [IW-1:0] rd_j,
  output logic [W-1:0]  rd_data
);
  localparam int N  = M * M;
  localparam int AW = $clog2(N);

  function automatic logic [AW-1:0] addr(input logic [IW-1:0] i, input logic [IW-1:0] j);
    return AW'(i) * AW'(M) + AW'(j);
  endfunction

  logic [W-1:0]  mem [N];
  logic [N-1:0]  written;
  logic [AW-1:0] wa;
  logic [AW-1:0] ra;

  assign wa      = addr(wr_i, wr_j);
  assign ra      = addr(rd_i, rd_j);
  assign wr_seen = written[wa];
  assign rd_data = mem[ra];

  // Data array carries no reset; only the bitmap says which entries are valid.
  always_ff @(posedge clk) begin
    if (we) mem[wa] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)     written     <= '0;
    else if (clr) written     <= '0;
    else if (we)  written[wa] <= 1'b1;
  end
endmodule

// File: rtl/matrix_result_collector.sv
// Collects out-of-order multiplier results into an M x M buffer, then drains the matrix row-major.
module matrix_result_collector
  import matmul_pkg::*;
#(
  parameter  int M  = 4,
  parameter  int W  = MAT_W,
  localparam int IW = $clog2(M)
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  matrix_result_collector_if.slave bus,
  output logic busy,
  output logic done,
  output logic dup_err
);
  localparam int CW = 2 * IW + 1;
  localparam int RW = 2 * IW;
  localparam logic [CW-1:0] COUNT_LAST = CW'(M * M - 1);
  localparam logic [RW-1:0] RD_LAST    = RW'(M * M - 1);
  localparam logic [RW-1:0] M_R        = RW'(M);

  coll_state_e   state_q, state_d;
  logic [CW-1:0] count;
  logic [RW-1:0] rd;
  logic          capture;
  logic          seen;
  logic          fresh;
  logic          beat;

  // The !z_ack term masks the still-high strobe during its own ack cycle; start pre-empts capture.
  assign capture   = (state_q == COLLECT) && bus.z_stb && !bus.z_ack && !start;
  assign fresh     = capture && !seen;
  assign beat      = (state_q == DRAIN) && bus.out_ready;
  assign bus.out_i = IW'(rd / M_R);
  assign bus.out_j = IW'(rd % M_R);

  result_store #(.M(M), .W(W)) u_store (
    .clk     (clk),
    .rst     (rst),
    .clr     (start),
    .we      (capture),
    .wr_i    (bus.z_i),
    .wr_j    (bus.z_j),
    .wr_data (bus.z_out),
    .wr_seen (seen),
    .rd_i    (bus.out_i),
    .rd_j    (bus.out_j),
    .rd_data (bus.out_data)
  );

  always_comb begin
    state_d       = state_q;
    busy          = 1'b0;
    done          = 1'b0;
    bus.out_valid = 1'b0;
    if (start) begin
      state_d = COLLECT;
    end else begin
      case (state_q)
        COLLECT: if (fresh && count == COUNT_LAST) state_d = DRAIN;
        DRAIN:   if (beat && rd == RD_LAST)        state_d = DONE;
        default: ;
      endcase
    end
    case (state_q)
      COLLECT: busy = 1'b1;
      DRAIN: begin
        busy          = 1'b1;
        bus.out_valid = 1'b1;
      end
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      count     <= '0;
      rd        <= '0;
      bus.z_ack <= 1'b0;
      dup_err   <= 1'b0;
    end else begin
      state_q   <= state_d;
      bus.z_ack <= capture;
      if (start) begin
        count   <= '0;
        rd      <= '0;
        dup_err <= 1'b0;
      end else begin
        if (fresh)           count   <= count + 1'b1;
        if (capture && seen) dup_err <= 1'b1;
        if (beat)            rd      <= (rd == RD_LAST) ? '0 : rd + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_matrix_result_collector.sv
// Scoreboard bench for matrix_result_collector with M=4.
module tb_matrix_result_collector;
  import matmul_pkg::*;

  typedef struct packed {
    logic [1:0]  i;
    logic [1:0]  j;
    logic [31:0] d;
  } beat_t;

  logic clk;
  logic rst;
  logic start;
  logic busy;
  logic done;
  logic dup_err;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_m [16];
  beat_t sb [$];

  matrix_result_collector_if #(.M(4), .W(32)) bus ();

  matrix_result_collector #(.M(4), .W(32)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .bus     (bus),
    .busy    (busy),
    .done    (done),
    .dup_err (dup_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, got timeout want finish");
    $fatal(1);
  end

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send(input int i, input int j, input logic [31:0] v);
    int t = 0;
    bus.z_i   = i[1:0];
    bus.z_j   = j[1:0];
    bus.z_out = v;
    bus.z_stb = 1'b1;
    do begin
      @(negedge clk);
      t++;
    end while (bus.z_ack !== 1'b1 && t < 20);
    bus.z_stb = 1'b0;
    checks++;
    if (bus.z_ack !== 1'b1) begin
      errors++;
      $display("FAIL ack_timeout (%0d,%0d): z_ack got %b want 1", i, j, bus.z_ack);
    end
    exp_m[i*4+j] = v;
  endtask

  task automatic load_sb();
    beat_t b;
    sb.delete();
    for (int r = 0; r < 16; r++) begin
      b.i = 2'(r / 4);
      b.j = 2'(r % 4);
      b.d = exp_m[r];
      sb.push_back(b);
    end
  endtask

  task automatic drain(input int mode, input string tag);
    int cyc = 0;
    int beats = 0;
    int k = 0;
    logic hold = 1'b0;
    logic rdy;
    beat_t e;
    beat_t p;
    while (sb.size() > 0 && cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (hold) begin
        checks++;
        if ({bus.out_data, bus.out_i, bus.out_j} !== {p.d, p.i, p.j}) begin
          errors++;
          $display("FAIL %s hold: got %h@(%0d,%0d) want %h@(%0d,%0d)", tag,
                   bus.out_data, bus.out_i, bus.out_j, p.d, p.i, p.j);
        end
      end
      checks++;
      if (bus.out_valid !== 1'b1) begin
        errors++;
        $display("FAIL %s out_valid: got %b want 1", tag, bus.out_valid);
        bus.out_ready = 1'b0;
        break;
      end
      e = sb[0];
      checks++;
      if (bus.out_data !== e.d || bus.out_i !== e.i || bus.out_j !== e.j) begin
        errors++;
        $display("FAIL %s beat: got %h@(%0d,%0d) want %h@(%0d,%0d)", tag,
                 bus.out_data, bus.out_i, bus.out_j, e.d, e.i, e.j);
      end
      rdy = (mode == 0) || (k % 4 == 0) || (k % 4 == 3);
      k++;
      bus.out_ready = rdy;
      if (rdy) begin
        void'(sb.pop_front());
        beats++;
        hold = 1'b0;
      end else begin
        hold = 1'b1;
        p.d = bus.out_data;
        p.i = bus.out_i;
        p.j = bus.out_j;
      end
    end
    @(negedge clk);
    bus.out_ready = 1'b0;
    checks++;
    if (done !== 1'b1 || bus.out_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL %s done: got done=%b valid=%b busy=%b want 1,0,0", tag, done, bus.out_valid, busy);
    end
    checks++;
    if (beats !== 16) begin
      errors++;
      $display("FAIL %s beats: got %0d want 16", tag, beats);
    end
    if (mode == 0) begin
      checks++;
      if (cyc !== 16) begin
        errors++;
        $display("FAIL %s drain_cycles: got %0d want 16", tag, cyc);
      end
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    @(negedge clk);
    checks++;
    if ({busy, done, dup_err, bus.z_ack, bus.out_valid, bus.out_i, bus.out_j} !== 9'b0) begin
      errors++;
      $display("FAIL reset_outputs: got %b want 0", {busy, done, dup_err, bus.z_ack, bus.out_valid, bus.out_i, bus.out_j});
    end
    checks++;
    if (dut.state_q !== IDLE || dut.count !== 5'd0 || dut.rd !== 4'd0) begin
      errors++;
      $display("FAIL reset_state: got state=%0d count=%0d rd=%0d want 0,0,0", dut.state_q, dut.count, dut.rd);
    end
    rst = 1'b1;
    bus.z_stb = 1'b1;
    @(negedge clk);
    @(negedge clk);
    bus.z_stb = 1'b0;
    checks++;
    if (busy !== 1'b0 || bus.z_ack !== 1'b0 || dut.count !== 5'd0) begin
      errors++;
      $display("FAIL idle_ignores_stb: got busy=%b ack=%b count=%0d want 0,0,0", busy, bus.z_ack, dut.count);
    end
  endtask

  task automatic test_in_order();
    pulse_start();
    checks++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      errors++;
      $display("FAIL in_order_busy: got busy=%b done=%b want 1,0", busy, done);
    end
    for (int r = 0; r < 16; r++) send(r / 4, r % 4, 32'(16 * (r / 4) + (r % 4)));
    checks++;
    if (dut.count !== 5'd16 || bus.out_valid !== 1'b1) begin
      errors++;
      $display("FAIL in_order_full: got count=%0d valid=%b want 16,1", dut.count, bus.out_valid);
    end
    load_sb();
    drain(0, "in_order");
  endtask

  task automatic test_out_of_order();
    pulse_start();
    checks++;
    if (done !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL restart_from_done: got done=%b busy=%b want 0,1", done, busy);
    end
    for (int r = 15; r >= 0; r--) send(r / 4, r % 4, $urandom);
    checks++;
    if (dup_err !== 1'b0) begin
      errors++;
      $display("FAIL reverse_dup: got %b want 0", dup_err);
    end
    load_sb();
    drain(0, "reverse");
    pulse_start();
    for (int d = 0; d < 4; d++)
      for (int i = 0; i < 4; i++) send(i, (i + d) % 4, $urandom);
    load_sb();
    drain(0, "diagonal");
  endtask

  task automatic test_handshake();
    int acks = 0;
    pulse_start();
    bus.z_i   = 2'd2;
    bus.z_j   = 2'd1;
    bus.z_out = 32'h0000_1234;
    bus.z_stb = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (bus.z_ack === 1'b1) acks++;
      if (k == 1) bus.z_stb = 1'b0;
    end
    exp_m[9] = 32'h0000_1234;
    checks++;
    if (acks !== 1) begin
      errors++;
      $display("FAIL hs_ack_pulses: got %0d want 1", acks);
    end
    checks++;
    if (dut.count !== 5'd1 || dup_err !== 1'b0) begin
      errors++;
      $display("FAIL hs_count: got count=%0d dup=%b want 1,0", dut.count, dup_err);
    end
    for (int r = 0; r < 16; r++) if (r != 9) send(r / 4, r % 4, $urandom);
    load_sb();
    drain(0, "handshake");
  endtask

  task automatic test_duplicate();
    pulse_start();
    send(1, 2, 32'h0000_AAAA);
    checks++;
    if (dut.count !== 5'd1 || dup_err !== 1'b0) begin
      errors++;
      $display("FAIL dup_first: got count=%0d dup=%b want 1,0", dut.count, dup_err);
    end
    send(1, 2, 32'h0000_BBBB);
    checks++;
    if (dut.count !== 5'd1 || dup_err !== 1'b1) begin
      errors++;
      $display("FAIL dup_second: got count=%0d dup=%b want 1,1", dut.count, dup_err);
    end
    for (int r = 0; r < 16; r++) if (r != 6) send(r / 4, r % 4, $urandom);
    load_sb();
    drain(0, "duplicate");
    checks++;
    if (dup_err !== 1'b1) begin
      errors++;
      $display("FAIL dup_sticky: got %b want 1", dup_err);
    end
  endtask

  task automatic test_backpressure();
    pulse_start();
    checks++;
    if (dup_err !== 1'b0) begin
      errors++;
      $display("FAIL start_clears_dup: got %b want 0", dup_err);
    end
    for (int r = 0; r < 16; r++) send(r / 4, r % 4, $urandom);
    load_sb();
    drain(1, "backpressure");
  endtask

  task automatic test_abort();
    pulse_start();
    send(0, 0, 32'h1111_0000);
    send(0, 0, 32'h1111_0001);
    for (int r = 1; r < 6; r++) send(r / 4, r % 4, $urandom);
    checks++;
    if (dut.count !== 5'd6 || dup_err !== 1'b1) begin
      errors++;
      $display("FAIL abort_pre: got count=%0d dup=%b want 6,1", dut.count, dup_err);
    end
    @(negedge clk);
    start     = 1'b1;
    bus.z_i   = 2'd3;
    bus.z_j   = 2'd3;
    bus.z_out = 32'hDEAD_BEEF;
    bus.z_stb = 1'b1;
    @(negedge clk);
    start     = 1'b0;
    bus.z_stb = 1'b0;
    checks++;
    if (bus.z_ack !== 1'b0 || dut.count !== 5'd0 || dup_err !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL abort_restart: got ack=%b count=%0d dup=%b busy=%b want 0,0,0,1",
               bus.z_ack, dut.count, dup_err, busy);
    end
    send(0, 0, 32'h2222_0000);
    checks++;
    if (dut.count !== 5'd1 || dup_err !== 1'b0) begin
      errors++;
      $display("FAIL abort_cleared: got count=%0d dup=%b want 1,0", dut.count, dup_err);
    end
    for (int r = 1; r < 16; r++) send(r / 4, r % 4, $urandom);
    load_sb();
    drain(0, "abort");
  endtask

  task automatic test_async_reset();
    pulse_start();
    for (int r = 0; r < 16; r++) send(r / 4, r % 4, $urandom);
    bus.out_ready = 1'b1;
    repeat (5) @(negedge clk);
    bus.out_ready = 1'b0;
    checks++;
    if (dut.rd !== 4'd5 || bus.out_i !== 2'd1 || bus.out_j !== 2'd1 || bus.out_valid !== 1'b1) begin
      errors++;
      $display("FAIL mid_drain: got rd=%0d (%0d,%0d) valid=%b want 5 (1,1) 1",
               dut.rd, bus.out_i, bus.out_j, bus.out_valid);
    end
    #2 rst = 1'b0;
    #1;
    checks++;
    if (dut.state_q !== IDLE || {busy, done, dup_err, bus.z_ack, bus.out_valid} !== 5'b0) begin
      errors++;
      $display("FAIL async_rst_ctrl: got state=%0d flags=%b want 0,0", dut.state_q,
               {busy, done, dup_err, bus.z_ack, bus.out_valid});
    end
    checks++;
    if (bus.out_i !== 2'd0 || bus.out_j !== 2'd0 || dut.count !== 5'd0 || dut.rd !== 4'd0) begin
      errors++;
      $display("FAIL async_rst_ptrs: got (%0d,%0d) count=%0d rd=%0d want 0", bus.out_i, bus.out_j,
               dut.count, dut.rd);
    end
    sb.delete();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (dut.state_q !== IDLE || busy !== 1'b0) begin
      errors++;
      $display("FAIL post_rst_idle: got state=%0d busy=%b want 0,0", dut.state_q, busy);
    end
  endtask

  initial begin
    rst           = 1'b0;
    start         = 1'b0;
    bus.z_stb     = 1'b0;
    bus.z_i       = '0;
    bus.z_j       = '0;
    bus.z_out     = '0;
    bus.out_ready = 1'b0;
    test_reset();
    test_in_order();
    test_out_of_order();
    test_handshake();
    test_duplicate();
    test_backpressure();
    test_abort();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
